// File: rtl/hard_mem_1rw_gen_wrapper.sv
// hard_mem_1rw_gen_wrapper
//   Parametrised single-port synchronous RAM with a valid/ready request port,
//   a read-valid strobe, a read-data hold register, generic write-mask expansion,
//   an optional post-reset zero-fill sequencer and out-of-range detection.
//   The storage is an la_spram-style array (ce/we/per-bit wmask, registered dout).
//
// Ports
//   clk_i      in   clock, rising edge
//   reset_n_i  in   asynchronous reset, active low
//   v_i        in   request valid
//   w_i        in   1 = write, 0 = read
//   addr_i     in   entry address [AW-1:0]
//   data_i     in   write data [DW-1:0]
//   w_mask_i   in   write lane enables [MW-1:0], lane k covers bits [k*MASK_GRAN +: MASK_GRAN]
//   ready_o    out  request accepted this cycle when v_i = 1
//   v_o        out  one-cycle strobe, data_o carries a read result
//   data_o     out  read data, holds the last read value between reads
//   err_o      out  one-cycle strobe, previous accepted request was out of range
module hard_mem_1rw_gen_wrapper #(
  parameter int unsigned DW        = 64,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned MASK_GRAN = 8,
  parameter int unsigned INIT_ZERO = 1,
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned MW       = DW / MASK_GRAN
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          v_i,
  input  logic          w_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic [MW-1:0] w_mask_i,
  output logic          ready_o,
  output logic          v_o,
  output logic [DW-1:0] data_o,
  output logic          err_o
);

  // Elaboration-time parameter checks.
  if (DW % MASK_GRAN != 0) begin : g_bad_mask_gran
    $error("DW must be a multiple of MASK_GRAN");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be at least 2");
  end

  localparam logic [AW:0]   DepthW   = DEPTH[AW:0];
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e        r_state;
  logic [AW-1:0] r_init_cnt;
  logic          r_rd_pend;
  logic          r_rd_oor;
  logic          r_err;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] r_mem_dout;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_accept;
  logic          w_in_range;
  logic          w_init_we;
  logic          w_ram_ce;
  logic          w_ram_we;
  logic          w_ram_re;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_din;
  logic [DW-1:0] w_mask_bits;
  logic [DW-1:0] w_ram_wmask;
  logic [DW-1:0] w_rd_data;

  // Gated by reset so the port reads not-ready while reset is held, yet is ready
  // on the very first cycle after release when no zero-fill is configured.
  assign ready_o    = (r_state == StReady) & reset_n_i;
  assign w_accept   = v_i & ready_o;
  assign w_in_range = ({1'b0, addr_i} < DepthW);
  assign w_init_we  = (r_state == StInit);

  // Lane-to-bit mask expansion.
  always_comb begin
    w_mask_bits = '0;
    for (int i = 0; i < int'(DW); i++) begin
      w_mask_bits[i] = w_mask_i[i / int'(MASK_GRAN)];
    end
  end

  // RAM control: the zero-fill sequencer owns the port while in StInit.
  assign w_ram_ce    = w_accept | w_init_we;
  assign w_ram_we    = w_init_we | (w_accept & w_i & w_in_range);
  assign w_ram_re    = w_accept & ~w_i & w_in_range;
  assign w_ram_addr  = w_init_we ? r_init_cnt : addr_i;
  assign w_ram_din   = w_init_we ? '0 : data_i;
  assign w_ram_wmask = w_init_we ? '1 : w_mask_bits;

  // Storage array; no reset on RAM contents.
  always_ff @(posedge clk_i) begin
    if (w_ram_ce && w_ram_we) begin
      r_mem[w_ram_addr] <= (r_mem[w_ram_addr] & ~w_ram_wmask) | (w_ram_din & w_ram_wmask);
    end
    if (w_ram_ce && w_ram_re) begin
      r_mem_dout <= r_mem[w_ram_addr];
    end
  end

  // Out-of-range reads return zero rather than whatever the array port holds.
  assign w_rd_data = r_rd_oor ? '0 : r_mem_dout;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= (INIT_ZERO != 0) ? StInit : StReady;
      r_init_cnt <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_oor   <= 1'b0;
      r_err      <= 1'b0;
      r_hold     <= '0;
    end else begin
      unique case (r_state)
        StInit: begin
          r_init_cnt <= r_init_cnt + AW'(1);
          if (r_init_cnt == LastAddr) begin
            r_state <= StReady;
          end
        end
        StReady: begin
          r_state <= StReady;
        end
        default: r_state <= StReady;
      endcase
      r_rd_pend <= w_accept & ~w_i;
      r_rd_oor  <= ~w_in_range;
      r_err     <= w_accept & ~w_in_range;
      if (r_rd_pend) begin
        r_hold <= w_rd_data;
      end
    end
  end

  assign v_o    = r_rd_pend;
  assign data_o = r_rd_pend ? w_rd_data : r_hold;
  assign err_o  = r_err;

endmodule

// File: tb/tb_hard_mem_1rw_gen_wrapper.sv
// Bench for hard_mem_1rw_gen_wrapper: two instances (64b/512 entries/byte mask and
// 7b/200 entries/bit mask), a cycle-level reference model per instance, a
// per-cycle compare process and directed checks with literal expectations.
module tb_hard_mem_1rw_gen_wrapper;

  localparam int A_DEPTH = 512;
  localparam int A_MW    = 8;
  localparam int B_DEPTH = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_v, a_w, a_ready, a_vo, a_err;
  logic [8:0]  a_addr;
  logic [63:0] a_data, a_do;
  logic [7:0]  a_mask;

  logic        b_v, b_w, b_ready, b_vo, b_err;
  logic [7:0]  b_addr;
  logic [6:0]  b_data, b_do;
  logic [6:0]  b_mask;

  hard_mem_1rw_gen_wrapper #(
    .DW(64), .DEPTH(A_DEPTH), .MASK_GRAN(8), .INIT_ZERO(1)
  ) u_dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(a_v), .w_i(a_w), .addr_i(a_addr),
    .data_i(a_data), .w_mask_i(a_mask), .ready_o(a_ready), .v_o(a_vo),
    .data_o(a_do), .err_o(a_err)
  );

  hard_mem_1rw_gen_wrapper #(
    .DW(7), .DEPTH(B_DEPTH), .MASK_GRAN(1), .INIT_ZERO(1)
  ) u_dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(b_v), .w_i(b_w), .addr_i(b_addr),
    .data_i(b_data), .w_mask_i(b_mask), .ready_o(b_ready), .v_o(b_vo),
    .data_o(b_do), .err_o(b_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model A: after reset, DEPTH cycles of not-ready, then every
  // valid request is served; a read result appears the following cycle.
  logic [63:0] ma_mem [A_DEPTH];
  int          ma_cyc;
  logic        ma_v, ma_err;
  logic [63:0] ma_last;

  always @(posedge clk or negedge rst_n) begin
    logic [63:0] m;
    logic        oor;
    if (!rst_n) begin
      ma_cyc = 0; ma_v = 1'b0; ma_err = 1'b0; ma_last = '0;
      for (int i = 0; i < A_DEPTH; i++) ma_mem[i] = '0;
    end else if (ma_cyc < A_DEPTH) begin
      ma_cyc++; ma_v = 1'b0; ma_err = 1'b0;
    end else begin
      ma_v = 1'b0; ma_err = 1'b0;
      if (a_v) begin
        oor = int'(a_addr) >= A_DEPTH;
        ma_err = oor;
        if (a_w) begin
          m = '0;
          for (int k = 0; k < A_MW; k++) if (a_mask[k]) m[k*8 +: 8] = 8'hFF;
          if (!oor) ma_mem[a_addr] = (ma_mem[a_addr] & ~m) | (a_data & m);
        end else begin
          ma_v = 1'b1;
          ma_last = oor ? 64'd0 : ma_mem[a_addr];
        end
      end
    end
  end

  // Reference model B: bit-granular mask, non-power-of-2 depth.
  logic [6:0] mb_mem [B_DEPTH];
  int         mb_cyc;
  logic       mb_v, mb_err;
  logic [6:0] mb_last;

  always @(posedge clk or negedge rst_n) begin
    logic oor;
    if (!rst_n) begin
      mb_cyc = 0; mb_v = 1'b0; mb_err = 1'b0; mb_last = '0;
      for (int i = 0; i < B_DEPTH; i++) mb_mem[i] = '0;
    end else if (mb_cyc < B_DEPTH) begin
      mb_cyc++; mb_v = 1'b0; mb_err = 1'b0;
    end else begin
      mb_v = 1'b0; mb_err = 1'b0;
      if (b_v) begin
        oor = int'(b_addr) >= B_DEPTH;
        mb_err = oor;
        if (b_w) begin
          if (!oor) mb_mem[b_addr] = (mb_mem[b_addr] & ~b_mask) | (b_data & b_mask);
        end else begin
          mb_v = 1'b1;
          mb_last = oor ? 7'd0 : mb_mem[b_addr];
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    chk("a_ready", 64'(a_ready), 64'(rst_n && (ma_cyc >= A_DEPTH)));
    chk("a_v_o",   64'(a_vo),    64'(ma_v));
    chk("a_err_o", 64'(a_err),   64'(ma_err));
    chk("a_data_o", a_do, ma_last);
    chk("b_ready", 64'(b_ready), 64'(rst_n && (mb_cyc >= B_DEPTH)));
    chk("b_v_o",   64'(b_vo),    64'(mb_v));
    chk("b_err_o", 64'(b_err),   64'(mb_err));
    chk("b_data_o", 64'(b_do),   64'(mb_last));
  end

  task automatic op_a(input logic v, input logic w, input logic [8:0] addr,
                      input logic [63:0] data, input logic [7:0] mask);
    @(posedge clk);
    #1;
    a_v = v; a_w = w; a_addr = addr; a_data = data; a_mask = mask;
  endtask

  task automatic op_b(input logic v, input logic w, input logic [7:0] addr,
                      input logic [6:0] data, input logic [6:0] mask);
    @(posedge clk);
    #1;
    b_v = v; b_w = w; b_addr = addr; b_data = data; b_mask = mask;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a;
    int cnt_b;
    rst_n = 1'b0;
    a_v = 1'b0; a_w = 1'b0; a_addr = '0; a_data = '0; a_mask = '0;
    b_v = 1'b0; b_w = 1'b0; b_addr = '0; b_data = '0; b_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_a_data", a_do, 64'd0);
    rst_n = 1'b1;

    // Requests during zero-fill are ignored; reset mid-fill restarts it.
    a_v = 1'b1; a_w = 1'b0; a_addr = 9'h1FF;
    b_v = 1'b1; b_w = 1'b0; b_addr = 8'd200;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("init_no_v_o", 64'(a_vo), 64'd0);
    chk("init_no_err_o", 64'(b_err), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_ready_low", 64'(a_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_v = 1'b0; b_v = 1'b0;

    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!b_ready) cnt_b++;
      if (a_ready) break;
      cnt_a++;
    end
    chk("a_fill_cycles", 64'(cnt_a), 64'd512);
    chk("b_fill_cycles", 64'(cnt_b), 64'd200);

    // Read of last entry after zero-fill.
    op_a(1'b1, 1'b0, 9'h1FF, 64'd0, 8'h00);
    op_a(1'b0, 1'b0, 9'h000, 64'd0, 8'h00);
    @(negedge clk);
    chk("t1_v_o", 64'(a_vo), 64'd1);
    chk("t1_data", a_do, 64'd0);

    // Byte-masked overwrite.
    op_a(1'b1, 1'b1, 9'h010, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    op_a(1'b1, 1'b1, 9'h010, 64'h0, 8'h0F);
    op_a(1'b1, 1'b0, 9'h010, 64'h0, 8'h00);
    op_a(1'b0, 1'b0, 9'h000, 64'h0, 8'h00);
    @(negedge clk);
    chk("t2_v_o", 64'(a_vo), 64'd1);
    chk("t2_data", a_do, 64'hDEADBEEF_00000000);
    chk("t2_model_pin", ma_last, 64'hDEADBEEF_00000000);

    // Back-to-back reads, then hold across a write.
    op_a(1'b1, 1'b1, 9'h001, 64'hA, 8'hFF);
    op_a(1'b1, 1'b1, 9'h002, 64'hB, 8'hFF);
    op_a(1'b1, 1'b1, 9'h003, 64'hC, 8'hFF);
    op_a(1'b1, 1'b0, 9'h001, 64'h0, 8'h00);
    op_a(1'b1, 1'b0, 9'h002, 64'h0, 8'h00);
    @(negedge clk);
    chk("t4_rd1", a_do, 64'hA);
    op_a(1'b1, 1'b0, 9'h003, 64'h0, 8'h00);
    @(negedge clk);
    chk("t4_rd2", a_do, 64'hB);
    op_a(1'b1, 1'b1, 9'h004, 64'h1234, 8'hFF);
    @(negedge clk);
    chk("t4_rd3", a_do, 64'hC);
    chk("t4_rd3_v", 64'(a_vo), 64'd1);
    op_a(1'b0, 1'b0, 9'h000, 64'h0, 8'h00);
    @(negedge clk);
    chk("t4_hold_v", 64'(a_vo), 64'd0);
    chk("t4_hold_data", a_do, 64'hC);

    // Read immediately after write to the same address.
    op_a(1'b1, 1'b1, 9'h020, 64'h0123_4567_89AB_CDEF, 8'hFF);
    op_a(1'b1, 1'b0, 9'h020, 64'h0, 8'h00);
    op_a(1'b0, 1'b0, 9'h000, 64'h0, 8'h00);
    @(negedge clk);
    chk("raw_data", a_do, 64'h0123_4567_89AB_CDEF);

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      op_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           9'($urandom_range(0, 15)), {$urandom, $urandom}, 8'($urandom));
    end
    op_a(1'b0, 1'b0, 9'h000, 64'h0, 8'h00);

    // Bit-mask instance.
    op_b(1'b1, 1'b1, 8'd5, 7'h7F, 7'h7F);
    op_b(1'b1, 1'b1, 8'd5, 7'h00, 7'h55);
    op_b(1'b1, 1'b0, 8'd5, 7'h00, 7'h00);
    op_b(1'b0, 1'b0, 8'd0, 7'h00, 7'h00);
    @(negedge clk);
    chk("t3_data", 64'(b_do), 64'h2A);

    // Out-of-range write and read.
    op_b(1'b1, 1'b1, 8'd200, 7'h55, 7'h7F);
    op_b(1'b0, 1'b0, 8'd0, 7'h00, 7'h00);
    @(negedge clk);
    chk("t5_wr_err", 64'(b_err), 64'd1);
    chk("t5_wr_no_v", 64'(b_vo), 64'd0);
    op_b(1'b1, 1'b0, 8'd200, 7'h00, 7'h00);
    op_b(1'b0, 1'b0, 8'd0, 7'h00, 7'h00);
    @(negedge clk);
    chk("t5_rd_v", 64'(b_vo), 64'd1);
    chk("t5_rd_data", 64'(b_do), 64'd0);
    chk("t5_rd_err", 64'(b_err), 64'd1);
    op_b(1'b1, 1'b0, 8'd72, 7'h00, 7'h00);
    op_b(1'b1, 1'b0, 8'd5, 7'h00, 7'h00);
    @(negedge clk);
    chk("t5_alias_untouched", 64'(b_do), 64'd0);
    op_b(1'b0, 1'b0, 8'd0, 7'h00, 7'h00);
    @(negedge clk);
    chk("t5_entry5_kept", 64'(b_do), 64'h2A);
    chk("t5_no_err", 64'(b_err), 64'd0);

    // Reset with a read in flight drops the result.
    op_a(1'b1, 1'b0, 9'h010, 64'h0, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    a_v = 1'b0;
    @(negedge clk);
    chk("rst_rd_dropped_v", 64'(a_vo), 64'd0);
    chk("rst_rd_dropped_data", a_do, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
